// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings: sequencer state values and add/sub opcode
//
// Purpose: single source for the serial adder FSM state encoding and the
//          op_sub opcode values, imported by the datapath modules.
// Ports:   none (package).
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/carry_look_ahead_adder.sv
// rtl/carry_look_ahead_adder.sv - 1-bit carry-look-ahead adder cell
//
// Purpose: per-bit sum and carry from generate/propagate terms.
// Ports:   a, b  - operand bits
//          cin   - carry in
//          s     - sum bit
//          cout  - carry out
module carry_look_ahead_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic g;
  logic p;

  assign g    = a & b;
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = g | (p & cin);

endmodule : carry_look_ahead_adder

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial add/subtract engine, LSB first, one bit per clock
//
// Purpose: time-multiplexes one 1-bit adder cell over WIDTH operand bits and
//          exposes a start/busy/done handshake.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          start, op_sub     - request and opcode (0 add, 1 subtract)
//          a, b              - operands, captured with an accepted start
//          busy, done        - high in RUN / one-cycle pulse in DONE
//          result            - sum/difference, held until next accepted start
//          cout, overflow    - carry out (1 = no borrow on subtract), signed overflow
//          zero              - result == 0
module serial_add_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               sum_bit;
  logic               c_next;

  carry_look_ahead_adder u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (sum_bit),
    .cout (c_next)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert B and seed the carry with 1.
          sa_d    = a;
          sb_d    = (op_sub == OP_SUB) ? ~b : b;
          carry_d = op_sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = c_next;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          cnt_d   = '0;
          state_d = DONE;
          cout_d  = c_next;
          ovf_d   = carry_q ^ c_next;
          zero_d  = (res_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - scoreboard bench for serial_add_sequencer
module tb_serial_add_sequencer;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op_sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   busy_run = 0;
  logic prev_done = 1'b0;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain modular and signed integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic iop);
    exp_t   e;
    longint sa;
    longint sb;
    longint exact;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (iop) begin
      e.res = ia - ib;
      e.co  = (ia >= ib);
      exact = sa - sb;
    end else begin
      e.res = ia + ib;
      e.co  = ({1'b0, ia} + {1'b0, ib}) > {1'b0, {WIDTH{1'b1}}};
      exact = sa + sb;
    end
    e.ov = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    e.z  = (e.res == '0);
    return e;
  endfunction

  // Issue one operation; called at a negedge. b2b demands acceptance in DONE.
  task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic iop, input bit b2b);
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", t);
    end
    if (b2b) check("b2b_in_done", done, 1);
    a      = ia;
    b      = ib;
    op_sub = iop;
    start  = 1'b1;
    exp_q.push_back(model(ia, ib, iop));
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    op_sub = 1'($urandom_range(0, 1));
    check("accept_busy", busy, 1);
  endtask

  // Monitor: pop and compare on every done pulse, and check busy length.
  always @(negedge clk) begin
    if (rst || (!busy && !done)) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        check("busy_len", busy_run, WIDTH);
        check("done_pulse_width", prev_done, 0);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with result 0x%0h, required no done", result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("cout", cout, e.co);
          check("overflow", overflow, e.ov);
          check("zero", zero, e.z);
        end
      end
    end
    prev_done = rst ? 1'b0 : done;
  end

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {cout, overflow, zero}, 0);

    do_op(32'd5, 32'd3, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
    do_op(32'd3, 32'd5, 1'b1, 1'b1);
    do_op(32'd5, 32'd3, 1'b1, 1'b1);
    do_op(32'h8000_0000, 32'd1, 1'b1, 1'b1);

    // Start ignored while busy, then reset mid-operation.
    repeat (40) @(negedge clk);
    do_op(32'd7, 32'd9, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", {cout, overflow, zero}, 0);
    do_op(32'd7, 32'd9, 1'b0, 1'b0);

    // Random operations with idle gaps and ignored mid-run starts.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        a = $urandom;
        b = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        while (busy) @(negedge clk);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("final_idle", {busy, done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_add_sequencer
